// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter granting one requester at a time to a single
// I2C master FSM, with start/abort strobes and a WAIT watchdog.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req             per-requester level request
//   req_addr        flattened slave addresses, ADDR_LEN per requester
//   req_rw          per-requester direction (1 = read)
//   req_wdata       flattened write bytes, DATA_LEN per requester
//   grant           one-hot bus owner
//   resp_valid      one-cycle response pulse to the owner
//   resp_status     00 OK, 01 NACK, 10 timeout
//   resp_rdata      read byte (zero for writes and errors)
//   m_start         one-cycle start strobe to the master
//   m_addr/rw/wdata latched transaction fields
//   m_abort         one-cycle abort strobe on watchdog expiry
//   m_busy          master not idle
//   m_done          master completion pulse
//   m_ack_err       slave NACK, valid with m_done
//   m_rdata         read byte, valid with m_done
module i2c_txn_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         resp_valid,
    output logic [1:0]                   resp_status,
    output logic [DATA_LEN-1:0]          resp_rdata,
    output logic                         m_start,
    output logic [ADDR_LEN-1:0]          m_addr,
    output logic                         m_rw,
    output logic [DATA_LEN-1:0]          m_wdata,
    output logic                         m_abort,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic                         m_ack_err,
    input  logic [DATA_LEN-1:0]          m_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST    = IW'(NUM_REQ - 1);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_TOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_win;
    logic [NUM_REQ-1:0]  r_grant;
    logic [ADDR_LEN-1:0] r_addr;
    logic                r_rw;
    logic [DATA_LEN-1:0] r_wdata;
    logic [CW-1:0]       r_cnt;
    logic [1:0]          r_status;
    logic [DATA_LEN-1:0] r_rdata;

    logic                w_found;
    logic [IW-1:0]       w_pick;
    int                  w_k;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [ADDR_LEN-1:0] w_sel_addr;
    logic [DATA_LEN-1:0] w_sel_wdata;
    logic [IW-1:0]       w_ptr_nxt;
    logic [DATA_LEN-1:0] w_rdata_cap;
    logic                w_start;
    logic                w_abort;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            if (!w_found && req[w_k[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_k[IW-1:0];
            end
        end
    end

    assign w_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_sel_addr  = req_addr[int'(w_pick)*ADDR_LEN +: ADDR_LEN];
    assign w_sel_wdata = req_wdata[int'(w_pick)*DATA_LEN +: DATA_LEN];
    assign w_ptr_nxt   = (r_win == LAST) ? '0 : r_win + 1'b1;

    // Read data is only meaningful for an acknowledged read.
    assign w_rdata_cap = (r_rw && !m_ack_err) ? m_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    w_start = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the final watchdog cycle beats the abort.
                if (m_done) begin
                    w_next = S_RESP;
                end else if (r_cnt == CNT_MAX) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_grant  <= '0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_rdata  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_win   <= w_pick;
                        r_addr  <= w_sel_addr;
                        r_rw    <= req_rw[w_pick];
                        r_wdata <= w_sel_wdata;
                    end
                end
                S_ISSUE: begin
                    if (w_start) begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (m_done) begin
                        r_status <= m_ack_err ? ST_NACK : ST_OK;
                        r_rdata  <= w_rdata_cap;
                    end else if (w_abort) begin
                        r_status <= ST_TOUT;
                        r_rdata  <= '0;
                    end
                end
                S_RESP: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign resp_valid  = (r_state == S_RESP);
    assign resp_status = r_status;
    assign resp_rdata  = r_rdata;
    assign m_start     = w_start;
    assign m_addr      = r_addr;
    assign m_rw        = r_rw;
    assign m_wdata     = r_wdata;
    assign m_abort     = w_abort;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Sits between N transaction requesters (CPU shim, sensor pollers, config loader) and the single I2C master FSM with its SCL generator.
- Arbitrates round-robin, latches the winner's address, direction and write byte, and issues one start strobe to the master.
- Waits for the master's done or a watchdog timeout, then returns read data and status to the winning requester.
- Guarantees only one transaction owns the bus at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_LEN, 7, slave address width.
- DATA_LEN, 8, data byte width.
- TIMEOUT, 4096, cycles allowed in WAIT before abort (must be >= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester level request.
- req_addr  in  NUM_REQ*ADDR_LEN  flattened slave addresses; requester i occupies bits [i*ADDR_LEN +: ADDR_LEN].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  NUM_REQ*DATA_LEN  flattened write bytes.
- grant  out  NUM_REQ  one-hot owner of the bus.
- resp_valid  out  1  one-cycle response pulse for the granted requester.
- resp_status  out  2  00 OK, 01 NACK, 10 timeout, 11 reserved.
- resp_rdata  out  DATA_LEN  read byte; zero for writes and errors.
- m_start  out  1  one-cycle start strobe to the master FSM.
- m_addr  out  ADDR_LEN  latched address.
- m_rw  out  1  latched direction.
- m_wdata  out  DATA_LEN  latched write byte.
- m_abort  out  1  one-cycle abort strobe; master forces Stop.
- m_busy  in  1  master not in Idle.
- m_done  in  1  one-cycle pulse on transaction completion.
- m_ack_err  in  1  valid with m_done; slave NACKed.
- m_rdata  in  DATA_LEN  valid with m_done.

Behaviour:
- Reset state: all outputs 0, priority pointer = 0, state IDLE, timeout counter 0. Reset mid-transaction returns to IDLE without pulsing m_abort.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, scanning upward with wrap.
  - On the same edge, register the one-hot grant, latch m_addr, m_rw and m_wdata from that requester, and go to ISSUE.
  - Latency: req sampled at edge k gives grant high after edge k.
- ISSUE:
  - m_start = 1 while !m_busy; it is a combinational output of the state.
  - The edge where m_start is 1 moves to WAIT and clears the timeout counter.
  - While m_busy = 1, hold in ISSUE with m_start = 0.
- WAIT:
  - The counter increments each cycle.
  - m_done = 1: capture m_rdata (forced to 0 if m_rw = 0 or m_ack_err = 1), set status to 01 if m_ack_err else 00, go to RESP.
  - Counter reaches TIMEOUT-1 without m_done: pulse m_abort for one cycle, set status 10, rdata 0, go to RESP.
  - If m_done and timeout coincide, m_done wins.
- RESP:
  - resp_valid = 1 for exactly one cycle with status and rdata held stable.
  - On that edge: grant clears, pointer = (winner+1) mod NUM_REQ, go to IDLE.
  - One idle cycle always separates consecutive grants.
- Grant and latched fields are frozen from grant until RESP exits. Requester inputs changing mid-transaction have no effect.
- A requester dropping req mid-transaction does not abort it; the response still pulses.
- m_done outside WAIT is ignored.
- Pointer wrap: winner NUM_REQ-1 → pointer 0.
- grant is at most one-hot in every cycle. resp_valid and m_start are never high in the same cycle.

Test Plan:
- Single write: NUM_REQ=4, req=0001, addr 0x50, wdata 0xA5, model m_done 40 cycles after m_start with ack_err=0 → grant=0001, m_addr=0x50, one m_start, resp_valid with status 00, rdata 0x00.
- Read with NACK: req=0100, rw=1, model returns ack_err=1, rdata 0x3C → status 01, resp_rdata 0x00; read OK variant → status 00, rdata 0x3C.
- Round-robin fairness: req=1111 held, model completes each transaction → grant order 0001, 0010, 0100, 1000, 0001; exactly one idle cycle between grants.
- Busy master: m_busy=1 for 10 cycles after grant → m_start stays 0 for those cycles, then pulses once when m_busy drops.
- Timeout: TIMEOUT=16, model never returns m_done → m_abort pulses exactly 16 cycles after the m_start cycle, status 10, grant released afterwards. Also coincident m_done at cycle 15 → status 00, no m_abort.
- Reset mid-WAIT and req drop: assert rst during WAIT → all outputs 0, pointer 0, no m_abort. Dropping req during WAIT → response still delivered to the original grant.
